// File: rtl/bcd_scan_display.sv
// Captures a 16-bit binary value on a rising load, converts it to BCD with a
// serial shift-add-3 engine and scans it onto a 4-digit 7-segment display.
module bcd_scan_display #(
    parameter int SCAN_DIV       = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] din,
    output logic        busy,
    output logic        ovf,
    output logic [6:0]  seg,
    output logic [3:0]  dig
);

    typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;

    localparam int            CW        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);
    localparam logic [6:0]    SEG_BLANK = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

    state_t        state, next_state;
    logic          load_q;
    logic          load_edge;
    logic [15:0]   bin;
    logic [19:0]   bcd;
    logic [19:0]   bcd_adj;
    logic [3:0]    bit_cnt;
    logic [15:0]   disp;
    logic [CW-1:0] scan_cnt;
    logic [3:0]    next_dig;
    logic [3:0]    cur_digit;
    logic          show;
    logic [6:0]    code;
    logic [6:0]    seg_next;

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    seg_code = 7'h3F;
            4'd1:    seg_code = 7'h06;
            4'd2:    seg_code = 7'h5B;
            4'd3:    seg_code = 7'h4F;
            4'd4:    seg_code = 7'h66;
            4'd5:    seg_code = 7'h6D;
            4'd6:    seg_code = 7'h7D;
            4'd7:    seg_code = 7'h07;
            4'd8:    seg_code = 7'h7F;
            4'd9:    seg_code = 7'h6F;
            default: seg_code = 7'h00;
        endcase
    endfunction

    assign load_edge = load & ~load_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= next_state;
    end

    always_comb begin
        // NOTE: default first so every path assigns next_state; otherwise a latch is inferred.
        next_state = state;
        case (state)
            IDLE:    if (load_edge) next_state = CONV;
            CONV:    if (bit_cnt == 4'd15) next_state = LOAD;
            LOAD:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Double-dabble correction on every nibble, including the top one.
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < 5; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        // NOTE: the displayed-digit register is reset too, so the display is "0" right after reset.
        if (!rst) begin
            load_q  <= 1'b0;
            busy    <= 1'b0;
            bin     <= '0;
            bcd     <= '0;
            bit_cnt <= '0;
            disp    <= '0;
            ovf     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            load_q <= load;
            busy   <= (next_state != IDLE);
            case (state)
                IDLE: if (load_edge) begin
                    bin     <= din;
                    bcd     <= '0;
                    bit_cnt <= '0;
                end
                CONV: begin
                    bcd     <= {bcd_adj[18:0], bin[15]};
                    bin     <= {bin[14:0], 1'b0};
                    bit_cnt <= bit_cnt + 4'd1;
                end
                LOAD: begin
                    disp <= bcd[15:0];
                    ovf  <= |bcd[19:16];
                end
                default: ;
            endcase
        end
    end

    // Segment data is computed for the digit about to be enabled so seg and dig move together.
    always_comb begin
        next_dig  = (scan_cnt == SCAN_LAST) ? {dig[2:0], dig[3]} : dig;
        cur_digit = 4'd0;
        show      = 1'b0;
        case (next_dig)
            4'b0001: begin cur_digit = disp[3:0];   show = 1'b1;          end
            4'b0010: begin cur_digit = disp[7:4];   show = |disp[15:4];   end
            4'b0100: begin cur_digit = disp[11:8];  show = |disp[15:8];   end
            4'b1000: begin cur_digit = disp[15:12]; show = |disp[15:12];  end
            default: ;
        endcase
        if (ovf)       code = 7'h40;
        else if (show) code = seg_code(cur_digit);
        else           code = 7'h00;
        seg_next = SEG_ACTIVE_LOW ? ~code : code;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scan_cnt <= '0;
            dig      <= 4'b0001;
            seg      <= SEG_BLANK;
        end else begin
            scan_cnt <= (scan_cnt == SCAN_LAST) ? '0 : scan_cnt + CW'(1);
            dig      <= next_dig;
            seg      <= seg_next;
        end
    end

endmodule

// File: tb/tb_bcd_scan_display.sv
// Self-checking bench for bcd_scan_display: arithmetic decimal display model,
// directed scenarios plus randomized values.
module tb_bcd_scan_display;

    logic       clk = 1'b0;
    logic       rst;
    logic       load;
    logic [15:0] din;
    logic       busy;
    logic       ovf;
    logic [6:0] seg;
    logic [3:0] dig;

    int checks   = 0;
    int failures = 0;

    // Results of the last load run and display capture.
    int         busy_cycles;
    int         busy_windows;
    logic       first_busy;
    logic       ovf_at_fall;
    logic       seen [4];
    logic [6:0] got  [4];
    int         bad_dig;

    bcd_scan_display #(.SCAN_DIV(4), .SEG_ACTIVE_LOW(1'b1)) dut (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .din  (din),
        .busy (busy),
        .ovf  (ovf),
        .seg  (seg),
        .dig  (dig)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (time=%0t)", $time);
        $fatal(1, "watchdog");
    end

    // Expected active-low segments for display position pos showing value v.
    function automatic logic [6:0] exp_seg(input int v, input int pos);
        int pow10 [4];
        logic [6:0] codes [10];
        int d;
        pow10 = '{1, 10, 100, 1000};
        codes = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        if (v > 9999) return ~7'h40;
        if (pos > 0 && v < pow10[pos]) return ~7'h00;
        d = (v / pow10[pos]) % 10;
        return ~codes[d];
    endfunction

    // Raise load with value v for 'hold' clock edges, then observe the busy window.
    task automatic run_load(input int v, input int hold);
        logic prev;
        @(negedge clk);
        din  = 16'(v);
        load = 1'b1;
        busy_cycles  = 0;
        busy_windows = 0;
        prev         = 1'b0;
        first_busy   = 1'b0;
        ovf_at_fall  = 1'bx;
        for (int i = 0; i < hold + 40; i++) begin
            @(negedge clk);
            if (i + 1 == hold) load = 1'b0;
            if (i == 0) first_busy = busy;
            if (busy === 1'b1) busy_cycles++;
            if (busy === 1'b1 && prev === 1'b0) busy_windows++;
            if (busy === 1'b0 && prev === 1'b1 && busy_windows == 1) ovf_at_fall = ovf;
            prev = busy;
        end
    endtask

    // Record the segment pattern seen for each enabled digit over a few scan rounds.
    task automatic capture_display();
        for (int p = 0; p < 4; p++) begin
            seen[p] = 1'b0;
            got[p]  = 7'hxx;
        end
        bad_dig = 0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            case (dig)
                4'b0001: begin seen[0] = 1'b1; got[0] = seg; end
                4'b0010: begin seen[1] = 1'b1; got[1] = seg; end
                4'b0100: begin seen[2] = 1'b1; got[2] = seg; end
                4'b1000: begin seen[3] = 1'b1; got[3] = seg; end
                default: bad_dig++;
            endcase
        end
    endtask

    task automatic test_reset();
        rst  = 1'b0;
        load = 1'b0;
        din  = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || ovf !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags: busy=%b ovf=%b expected 0/0", busy, ovf);
        end
        checks++;
        if (dig !== 4'b0001 || seg !== 7'h7F) begin
            failures++;
            $display("FAIL reset_scan: dig=%b seg=%h expected 0001/7f", dig, seg);
        end
        rst = 1'b1;
        capture_display();
        for (int p = 0; p < 4; p++) begin
            checks++;
            if (seen[p] !== 1'b1 || got[p] !== exp_seg(0, p)) begin
                failures++;
                $display("FAIL reset_display pos%0d: seen=%b seg=%h expected %h", p, seen[p], got[p], exp_seg(0, p));
            end
        end
        checks++;
        if (bad_dig != 0) begin
            failures++;
            $display("FAIL reset_dig_onehot: %0d bad samples expected 0", bad_dig);
        end
    endtask

    // Load v, then compare busy timing, ovf and all four digits against the model.
    task automatic test_value(input string name, input int v, input int hold);
        run_load(v, hold);
        checks++;
        if (first_busy !== 1'b1) begin
            failures++;
            $display("FAIL %s busy_start: busy=%b expected 1 after capture edge", name, first_busy);
        end
        checks++;
        if (busy_windows != 1 || busy_cycles != 17) begin
            failures++;
            $display("FAIL %s busy_window: windows=%0d cycles=%0d expected 1/17", name, busy_windows, busy_cycles);
        end
        checks++;
        if (ovf_at_fall !== (v > 9999)) begin
            failures++;
            $display("FAIL %s ovf_at_busy_fall: ovf=%b expected %b", name, ovf_at_fall, v > 9999);
        end
        capture_display();
        for (int p = 0; p < 4; p++) begin
            checks++;
            if (seen[p] !== 1'b1 || got[p] !== exp_seg(v, p)) begin
                failures++;
                $display("FAIL %s display pos%0d: seen=%b seg=%h expected %h", name, p, seen[p], got[p], exp_seg(v, p));
            end
        end
        checks++;
        if (ovf !== (v > 9999)) begin
            failures++;
            $display("FAIL %s ovf: ovf=%b expected %b", name, ovf, v > 9999);
        end
    endtask

    task automatic test_convert();
        test_value("convert_1234", 1234, 1);
    endtask

    task automatic test_held_load();
        test_value("held_load_7", 7, 50);
    endtask

    task automatic test_overflow();
        test_value("ovf_10000", 10000, 1);
        test_value("ovf_65535", 65535, 1);
        test_value("clear_9999", 9999, 1);
    endtask

    task automatic test_ignored_edge();
        int bcount;
        int inj_at;
        int windows;
        logic prev;
        @(negedge clk);
        din     = 16'd42;
        load    = 1'b1;
        bcount  = 0;
        inj_at  = -1;
        windows = 0;
        prev    = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (i == 0) load = 1'b0;
            if (busy === 1'b1) bcount++;
            if (busy === 1'b1 && prev === 1'b0) windows++;
            prev = busy;
            if (bcount == 5 && inj_at < 0) begin
                din    = 16'd5;
                load   = 1'b1;
                inj_at = i;
            end else if (inj_at >= 0 && i == inj_at + 1) begin
                load = 1'b0;
            end
        end
        checks++;
        if (windows != 1 || bcount != 17) begin
            failures++;
            $display("FAIL ignored_edge busy: windows=%0d cycles=%0d expected 1/17", windows, bcount);
        end
        capture_display();
        for (int p = 0; p < 4; p++) begin
            checks++;
            if (got[p] !== exp_seg(42, p)) begin
                failures++;
                $display("FAIL ignored_edge display pos%0d: seg=%h expected %h", p, got[p], exp_seg(42, p));
            end
        end
        test_value("after_ignored_5", 5, 1);
    endtask

    task automatic test_reset_mid_conv();
        int bcount;
        @(negedge clk);
        din    = 16'd8888;
        load   = 1'b1;
        bcount = 0;
        for (int i = 0; i < 40 && bcount < 8; i++) begin
            @(negedge clk);
            load = 1'b0;
            if (busy === 1'b1) bcount++;
        end
        checks++;
        if (bcount != 8) begin
            failures++;
            $display("FAIL mid_reset reach: busy cycles=%0d expected 8", bcount);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || ovf !== 1'b0 || dig !== 4'b0001 || seg !== 7'h7F) begin
            failures++;
            $display("FAIL mid_reset state: busy=%b ovf=%b dig=%b seg=%h expected 0/0/0001/7f", busy, ovf, dig, seg);
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (30) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset no_resume: busy=%b expected 0", busy);
        end
        capture_display();
        for (int p = 0; p < 4; p++) begin
            checks++;
            if (got[p] !== exp_seg(0, p)) begin
                failures++;
                $display("FAIL mid_reset display pos%0d: seg=%h expected %h", p, got[p], exp_seg(0, p));
            end
        end
        test_value("after_reset_321", 321, 1);
    endtask

    task automatic test_random();
        int v;
        for (int n = 0; n < 12; n++) begin
            case (n % 3)
                0:       v = int'($urandom_range(0, 99));
                1:       v = int'($urandom_range(0, 9999));
                default: v = int'($urandom_range(0, 65535));
            endcase
            test_value($sformatf("random_%0d", v), v, 1 + int'($urandom_range(0, 3)));
        end
    endtask

    initial begin
        test_reset();
        test_convert();
        test_held_load();
        test_overflow();
        test_ignored_edge();
        test_reset_mid_conv();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
